// File: rtl/seq_mult_hs_if.sv
// Handshake bundle for the sequential multiplier: operand channel in, product channel out.
interface seq_mult_hs_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic           in_signed;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out;

    modport master (
        output in_valid, in_signed, a, b, out_ready,
        input  in_ready, out_valid, out
    );

    modport slave (
        input  in_valid, in_signed, a, b, out_ready,
        output in_ready, out_valid, out
    );
endinterface

// File: rtl/seq_mult_hs.sv
// Sequential shift-add multiplier: one multiplier bit per clock, fixed N-cycle latency,
// signed or unsigned per transaction, valid/ready on both sides.
module seq_mult_hs #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    seq_mult_hs_if.slave bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2*N:0]     acc_q, acc_d;
    logic [N-1:0]     mcand_q, mcand_d;
    logic [N-1:0]     mplier_q, mplier_d;
    logic             neg_q, neg_d;
    logic [2*N-1:0]   out_q, out_d;
    logic             out_valid_q, out_valid_d;

    logic             accept;
    logic [N-1:0]     a_mag;
    logic [N-1:0]     b_mag;
    logic [N:0]       upper_sum;
    logic [2*N:0]     acc_step;

    // A new transaction can enter when idle, or when the held result is leaving this edge.
    assign bus.in_ready  = (state_q == IDLE) | ((state_q == DONE) & bus.out_ready);
    assign accept        = bus.in_valid & bus.in_ready;
    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;

    // Operand magnitudes; the most negative value maps onto 2^(N-1) as an unsigned N-bit number.
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        if (bus.in_signed) begin
            if (bus.a[N-1]) a_mag = -bus.a;
            if (bus.b[N-1]) b_mag = -bus.b;
        end
    end

    // One shift-add iteration: conditionally add the multiplicand into the upper half, then shift.
    always_comb begin
        upper_sum = acc_q[2*N:N] + {1'b0, (mplier_q[0] ? mcand_q : {N{1'b0}})};
        acc_step  = {upper_sum, acc_q[N-1:0]} >> 1;
    end

    // Next-state and datapath control; an accept overrides whatever the current state would do.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            RUN: begin
                acc_d    = acc_step;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    out_d       = neg_q ? -acc_step[2*N-1:0] : acc_step[2*N-1:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (accept) begin
            state_d  = RUN;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = a_mag;
            mplier_d = b_mag;
            neg_d    = bus.in_signed & (bus.a[N-1] ^ bus.b[N-1]);
        end
    end

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule
